// File: rtl/dmem_subword.sv
// Data memory with byte/halfword/word access, little-endian lanes, fault detection
// and a req/ready handshake with a configurable number of wait states.
module dmem_subword #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          bad;
  logic          accept;
  logic          commit;
  logic [3:0]    wmask;
  logic [31:0]   wword;
  logic [31:0]   shifted;
  logic [31:0]   load_val;

  assign idx    = addr_q[AW+1:2];
  assign lane   = addr_q[1:0];
  assign accept = req && (state == IDLE || state == DONE);
  assign commit = (state == DONE) && we_q && !bad;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    bad = 1'b0;
    case (size_q)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_q[0];
      2'b10:   bad = |addr_q[1:0];
      default: bad = 1'b1;
    endcase
    if ((addr_q >> (AW + 2)) != 32'd0) bad = 1'b1;
  end

  // Store data is replicated across lanes; the mask picks which lanes actually change.
  always_comb begin
    wmask = 4'b0000;
    wword = wdata_q;
    case (size_q)
      2'b00: begin
        wmask = 4'b0001 << lane;
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wmask = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      2'b10:   wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
  end

  always_comb begin
    shifted  = mem[idx] >> {lane, 3'b000};
    load_val = 32'd0;
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      2'b10:   load_val = shifted;
      default: load_val = 32'd0;
    endcase
  end

  // NOTE: the array is deliberately left out of reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      fault   <= 1'b0;
      rdata   <= 32'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
    end else begin
      ready <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: ;
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          ready <= 1'b1;
          fault <= bad;
          if (!we_q) rdata <= bad ? 32'd0 : load_val;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A new request overrides the default next state, including back-to-back from DONE.
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        size_q  <= size;
        we_q    <= we;
        uns_q   <= uns;
        cnt     <= 4'(WAIT_CYCLES);
        if (WAIT_CYCLES == 0) begin
          state <= DONE;
          busy  <= 1'b0;
        end else begin
          state <= WAIT;
          busy  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_subword.sv
// Self-checking bench for dmem_subword: directed scenarios plus randomized traffic
// against a byte-array reference model, over four wait-state configurations.
module tb_dmem_subword;

  localparam int NI = 4;

  logic        clk;
  logic        rst_n;
  logic        req   [NI];
  logic        we    [NI];
  logic [1:0]  size  [NI];
  logic        uns   [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic        ready [NI];
  logic        fault [NI];
  logic        busy  [NI];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  refm    [NI][1024];
  logic [31:0] last_rd [NI];

  typedef struct {
    bit          w;
    logic [1:0]  sz;
    bit          u;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] erd;
    bit          ef;
  } op_t;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 2 : 7;
    dmem_subword #(.DEPTH(256), .WAIT_CYCLES(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req[g]), .we(we[g]), .size(size[g]),
      .uns(uns[g]), .addr(addr[g]), .wdata(wdata[g]), .rdata(rdata[g]),
      .ready(ready[g]), .fault(fault[g]), .busy(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int i);
    case (i)
      0:       return 0;
      1:       return 3;
      2:       return 2;
      default: return 7;
    endcase
  endfunction

  // Reference: byte-addressed memory, fault rules and extension applied arithmetically.
  function automatic void model(input int i, input bit w, input logic [1:0] sz, input bit u,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] erd, output bit ef);
    int n;
    logic [31:0] v;
    ef  = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= 1024);
    erd = last_rd[i];
    if (!ef) begin
      n = 1 << sz;
      if (w) begin
        for (int k = 0; k < n; k++) refm[i][a + k] = d[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(refm[i][a + k]) << (8 * k));
        if (!u && n == 1 && v >= 32'h80)   v = v + 32'hffffff00;
        if (!u && n == 2 && v >= 32'h8000) v = v + 32'hffff0000;
        erd = v;
      end
    end else if (!w) begin
      erd = 32'd0;
    end
    last_rd[i] = erd;
  endfunction

  task automatic access(input int i, input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output bit f, output int lat);
    int k;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; size[i] = sz; uns[i] = u; addr[i] = a; wdata[i] = d;
    @(negedge clk);
    req[i] = 1'b0; we[i] = 1'($urandom); size[i] = 2'($urandom);
    uns[i] = 1'($urandom); addr[i] = $urandom; wdata[i] = $urandom;
    k = 0;
    while (ready[i] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    lat = k;
    rd  = rdata[i];
    f   = fault[i];
  endtask

  task automatic run_table(input string name, input int i, input op_t ops[]);
    logic [31:0] rd;
    bit f;
    int lat;
    foreach (ops[j]) begin
      access(i, ops[j].w, ops[j].sz, ops[j].u, ops[j].a, ops[j].d, rd, f, lat);
      n_checks++;
      if (rd !== ops[j].erd || f !== ops[j].ef || lat != 1 + wc(i)) begin
        n_fail++;
        $display("FAIL %s[%0d]: rdata=%h fault=%b latency=%0d, expected rdata=%h fault=%b latency=%0d",
                 name, j, rd, f, lat, ops[j].erd, ops[j].ef, 1 + wc(i));
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req[i] = 0; we[i] = 0; size[i] = 0; uns[i] = 0; addr[i] = 0; wdata[i] = 0; last_rd[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if ({ready[i], fault[i], busy[i]} !== 3'b000 || rdata[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: ready=%b fault=%b busy=%b rdata=%h, expected all 0",
                 i, ready[i], fault[i], busy[i], rdata[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_word_subword;
    op_t ops[] = '{
      '{1, 2'd2, 0, 32'h10, 32'h8badf00d, 32'h00000000, 0},
      '{0, 2'd2, 0, 32'h10, 32'h0,        32'h8badf00d, 0},
      '{1, 2'd0, 0, 32'h11, 32'h000000aa, 32'h8badf00d, 0},
      '{0, 2'd2, 0, 32'h10, 32'h0,        32'h8badaa0d, 0},
      '{0, 2'd0, 0, 32'h11, 32'h0,        32'hffffffaa, 0},
      '{0, 2'd0, 1, 32'h11, 32'h0,        32'h000000aa, 0},
      '{1, 2'd1, 0, 32'h12, 32'h00001234, 32'h000000aa, 0},
      '{0, 2'd2, 0, 32'h10, 32'h0,        32'h1234aa0d, 0},
      '{0, 2'd1, 0, 32'h12, 32'h0,        32'h00001234, 0}
    };
    run_table("word_subword", 0, ops);
  endtask

  task automatic test_faults;
    op_t ops[] = '{
      '{1, 2'd2, 0, 32'h14,  32'h55667788, 32'h00001234, 0},
      '{0, 2'd2, 0, 32'h10,  32'h0,        32'h1234aa0d, 0},
      '{0, 2'd2, 0, 32'h13,  32'h0,        32'h00000000, 1},
      '{0, 2'd2, 0, 32'h10,  32'h0,        32'h1234aa0d, 0},
      '{0, 2'd1, 0, 32'h11,  32'h0,        32'h00000000, 1},
      '{0, 2'd2, 0, 32'h10,  32'h0,        32'h1234aa0d, 0},
      '{0, 2'd3, 0, 32'h10,  32'h0,        32'h00000000, 1},
      '{0, 2'd2, 0, 32'h10,  32'h0,        32'h1234aa0d, 0},
      '{0, 2'd2, 0, 32'h400, 32'h0,        32'h00000000, 1},
      '{0, 2'd2, 0, 32'h14,  32'h0,        32'h55667788, 0},
      '{1, 2'd2, 0, 32'h16,  32'hffffffff, 32'h55667788, 1},
      '{0, 2'd2, 0, 32'h14,  32'h0,        32'h55667788, 0}
    };
    run_table("faults", 0, ops);
  endtask

  task automatic test_wait;
    logic [31:0] rd;
    bit f;
    int lat;
    @(negedge clk);
    req[1] = 1; we[1] = 1; size[1] = 2'd2; uns[1] = 0; addr[1] = 32'h40; wdata[1] = 32'hcafe0040;
    @(negedge clk);
    req[1] = 0;
    for (int k = 0; k <= 12; k++) begin
      n_checks++;
      if (busy[1] !== (k < 3) || ready[1] !== (k == 4)) begin
        n_fail++;
        $display("FAIL wait_timing[k=%0d]: busy=%b ready=%b, expected busy=%b ready=%b",
                 k, busy[1], ready[1], k < 3, k == 4);
      end
      if (k == 1) begin
        req[1] = 1; we[1] = 0; addr[1] = 32'h44;
      end
      if (k == 2) req[1] = 0;
      @(negedge clk);
    end
    access(1, 0, 2'd2, 0, 32'h40, 32'h0, rd, f, lat);
    n_checks++;
    if (rd !== 32'hcafe0040 || f !== 1'b0 || lat != 4) begin
      n_fail++;
      $display("FAIL wait_readback: rdata=%h fault=%b latency=%0d, expected cafe0040 0 4", rd, f, lat);
    end
  endtask

  task automatic test_back_to_back;
    bit er;
    @(negedge clk);
    req[1] = 1; we[1] = 0; size[1] = 2'd2; uns[1] = 0; addr[1] = 32'h40;
    @(negedge clk);
    for (int k = 0; k <= 20; k++) begin
      er = (k > 0) && (k % 4 == 0) && (k <= 16);
      n_checks++;
      if (ready[1] !== er || (er && rdata[1] !== 32'hcafe0040)) begin
        n_fail++;
        $display("FAIL back_to_back[k=%0d]: ready=%b rdata=%h, expected ready=%b rdata=cafe0040",
                 k, ready[1], rdata[1], er);
      end
      if (k == 12) req[1] = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd;
    bit f;
    int lat;
    int pulses;
    access(1, 1, 2'd2, 0, 32'h20, 32'h11112222, rd, f, lat);
    @(negedge clk);
    req[1] = 1; we[1] = 1; size[1] = 2'd2; addr[1] = 32'h20; wdata[1] = 32'hdeadbeef;
    @(negedge clk);
    req[1] = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready[1], fault[1], busy[1]} !== 3'b000 || rdata[1] !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: ready=%b fault=%b busy=%b rdata=%h, expected all 0",
               ready[1], fault[1], busy[1], rdata[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) last_rd[i] = 32'd0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (ready[1] === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL abort_no_ready: %0d ready pulses, expected 0", pulses);
    end
    access(1, 0, 2'd2, 0, 32'h20, 32'h0, rd, f, lat);
    n_checks++;
    if (rd !== 32'h11112222 || f !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_readback: rdata=%h fault=%b, expected 11112222 0", rd, f);
    end
  endtask

  task automatic random_run(input int i, input int nops);
    logic [31:0] rd, erd, a, d;
    logic [1:0] sz;
    bit f, ef, w, u;
    int lat, r;
    for (int j = 0; j < 256 + nops; j++) begin
      d = $urandom;
      if (j < 256) begin
        w = 1; sz = 2'd2; u = 0; a = 32'(j * 4);
      end else begin
        w  = 1'($urandom);
        u  = 1'($urandom);
        r  = $urandom_range(0, 99);
        sz = (r < 5) ? 2'd3 : 2'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 1023));
        r  = $urandom_range(0, 99);
        if (r < 5)        a = a | ($urandom << 10) | 32'h400;
        else if (r >= 15 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      end
      model(i, w, sz, u, a, d, erd, ef);
      access(i, w, sz, u, a, d, rd, f, lat);
      n_checks++;
      if (rd !== erd || f !== ef || lat != 1 + wc(i)) begin
        n_fail++;
        $display("FAIL random[inst=%0d op=%0d we=%b size=%0d uns=%b addr=%h]: rdata=%h fault=%b latency=%0d, expected rdata=%h fault=%b latency=%0d",
                 i, j, w, sz, u, a, rd, f, lat, erd, ef, 1 + wc(i));
      end
    end
  endtask

  task automatic test_random;
    fork
      random_run(0, 3334);
      random_run(2, 3333);
      random_run(3, 3333);
    join
  endtask

  initial begin
    test_reset;
    test_word_subword;
    test_faults;
    test_wait;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_subword.md
# dmem_subword

Parametrised data memory for the MIPS 32 datapath, successor to the single-word data memory. Adds byte and halfword access (LB/LBU/LH/LHU/LW, SB/SH/SW) with little-endian byte lanes, sign/zero extension on loads, alignment and range fault detection, and a req/ready handshake with configurable wait states so slower memory timing can be modelled. It sits between the ALU result / rt-register path and the write-back mux.

## Interface

- DEPTH, 256, number of 32-bit words; must be a power of two ≥ 4
- WAIT_CYCLES, 0, extra cycles inserted before completion; legal range 0..15

- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  1  access request; sampled only when busy=0
- we  input  1  1 = store, 0 = load; sampled with req
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (faults)
- uns  input  1  1 = zero-extend sub-word load, 0 = sign-extend
- addr  input  32  byte address
- wdata  input  32  store data; the low byte/half is used for sub-word stores
- rdata  output  32  load result; held until the next completion
- ready  output  1  one-cycle completion pulse
- fault  output  1  valid with ready; access rejected
- busy  output  1  request in flight; req ignored

## Operation

- Word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0]; byte lane 0 = bits 7:0.
- Fault conditions, checked on the latched request:
  - size=11
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
  - addr[31:log2(DEPTH)+2] nonzero (out of range)
- Faulted access: no memory change; ready=1 with fault=1; rdata forced to 0 for loads, unchanged for stores.
- Store byte: writes wdata[7:0] into the lane selected by addr[1:0]; other lanes are preserved.
- Store half: writes wdata[15:0] into lanes {addr[1],1} and {addr[1],0}.
- Store word: writes all four lanes.
- Load: selects the lane(s), then extends to 32 bits; sign source is bit 7 (byte) or bit 15 (half) when uns=0.
- Store completion leaves rdata unchanged.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on req=1, latch addr/we/size/uns/wdata, load wait counter with WAIT_CYCLES, go to WAIT (or DONE if WAIT_CYCLES=0).
  - WAIT: decrement the counter; when it reaches 0 go to DONE.
  - DONE: ready=1 for one cycle; the memory write commits on the edge leaving DONE... stated precisely in Timing.
  - From DONE: if req=1, accept a new request (back-to-back), otherwise return to IDLE.
- busy=1 in WAIT, and in IDLE→WAIT transition cycles; busy=0 in IDLE and DONE.
- Memory array is not cleared by reset; contents are undefined until written.

## Timing

- Request accepted at edge N (req=1, busy=0).
- ready/fault/rdata are registered, and become valid after edge N+1+WAIT_CYCLES.
  - WAIT_CYCLES=0: ready is high in the cycle after acceptance.
  - Throughput: one access per 1+WAIT_CYCLES cycles.
- The store array update occurs on the same edge that asserts ready. A load issued in the DONE cycle of a store returns the new data.
- Inputs may change freely after acceptance; only latched values are used.
- req while busy=1: ignored, not queued.
- Reset values: ready=0, fault=0, busy=0, rdata=0, FSM=IDLE, counter=0.
- rst_n asserted mid-access: the access is aborted; no write commits and no ready pulse follows deassertion.

## Test plan

- WAIT_CYCLES=0. SW 0x8badf00d to addr 0x10, then LW 0x10 -> ready 1 cycle after each req; rdata=0x8badf00d, fault=0.
- Sub-word stores and loads:
  - SB 0xAA to 0x11, then LW 0x10 -> 0x8badaa0d.
  - LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA.
  - SH 0x1234 to 0x12, then LW 0x10 -> 0x1234aa0d.
  - LH 0x12 -> 0x00001234.
- Faults:
  - LW 0x13, LH 0x11, size=11, and address 4*DEPTH -> each gives ready=1, fault=1, rdata=0.
  - SW 0x14 misaligned (0x16) -> memory at 0x14 unchanged on readback.
- WAIT_CYCLES=3: req at edge N -> busy for 3 cycles, ready after edge N+4. A req pulsed while busy is ignored (exactly one ready). Back-to-back req held high -> a ready every 4 cycles.
- Reset:
  - Assert rst_n low during WAIT of SW 0xdeadbeef to 0x20 -> ready never pulses; a later LW 0x20 returns the old value.
  - All outputs read 0 during reset.
- Random mixed access against a byte-array reference model, 10k ops, WAIT_CYCLES ∈ {0,2,7} -> zero mismatches.
